// File: rtl/irrigation_zone_scheduler.sv
// Shares one pump among NZONES irrigation zones: urgent-first round-robin grant,
// then valve-open settle, timed pump run, and valve-close settle per zone.
module irrigation_zone_scheduler #(
   parameter int NZONES = 4,
   parameter int ZW     = 2,
   parameter int TIME_W = 7,
   parameter int SETTLE = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NZONES-1:0]        req,
   input  logic [NZONES-1:0]        urgent,
   input  logic [NZONES*TIME_W-1:0] water_time,
   output logic [NZONES-1:0]        valve,
   output logic                     pump_on,
   output logic [ZW-1:0]            active_zone,
   output logic [NZONES-1:0]        done,
   output logic [1:0]               state
);
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OPEN  = 2'b01,
      WATER = 2'b10,
      CLOSE = 2'b11
   } state_t;

   localparam int SW    = $clog2(SETTLE + 1);
   localparam int CNT_W = (TIME_W > SW) ? TIME_W : SW;
   localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

   state_t            fsm;
   logic [ZW-1:0]     ptr;
   logic [TIME_W-1:0] t_lat;
   logic [CNT_W-1:0]  cnt;

   logic [TIME_W-1:0] times [NZONES];
   logic [NZONES-1:0] cand;
   logic [ZW-1:0]     winner;
   logic [TIME_W-1:0] win_time;

   function automatic logic [ZW-1:0] wrap_inc(input logic [ZW-1:0] z);
      return (int'(z) == NZONES - 1) ? '0 : z + 1'b1;
   endfunction

   function automatic logic [NZONES-1:0] onehot(input logic [ZW-1:0] z);
      return NZONES'(1) << z;
   endfunction

   // First candidate at or after p, scanning upward with wrap.
   function automatic logic [ZW-1:0] rr_pick(input logic [NZONES-1:0] c,
                                             input logic [ZW-1:0] p);
      logic [ZW-1:0] w;
      logic [ZW-1:0] idx;
      logic          found;
      w     = p;
      idx   = p;
      found = 1'b0;
      for (int i = 0; i < NZONES; i++) begin
         if (!found && c[idx]) begin
            w     = idx;
            found = 1'b1;
         end
         idx = wrap_inc(idx);
      end
      return w;
   endfunction

   for (genvar i = 0; i < NZONES; i++) begin : g_time
      assign times[i] = water_time[i*TIME_W +: TIME_W];
   end

   always_comb begin
      cand     = ((req & urgent) != '0) ? (req & urgent) : req;
      winner   = rr_pick(cand, ptr);
      win_time = times[winner];
   end

   assign state = fsm;

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm         <= IDLE;
         valve       <= '0;
         pump_on     <= 1'b0;
         done        <= '0;
         active_zone <= '0;
         ptr         <= '0;
         t_lat       <= '0;
         cnt         <= '0;
      end else begin
         done <= '0;
         case (fsm)
            IDLE: begin
               if (enable && req != '0) begin
                  active_zone <= winner;
                  t_lat       <= win_time;
                  // A zero duration is served as an immediate skip, no valve cycling.
                  if (win_time == '0) begin
                     done <= onehot(winner);
                     ptr  <= wrap_inc(winner);
                  end else begin
                     valve <= onehot(winner);
                     cnt   <= SETTLE_M1;
                     fsm   <= OPEN;
                  end
               end
            end
            OPEN: begin
               if (!enable) begin
                  fsm <= CLOSE;
                  cnt <= SETTLE_M1;
               end else if (cnt == '0) begin
                  fsm     <= WATER;
                  pump_on <= 1'b1;
                  cnt     <= CNT_W'(t_lat) - 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WATER: begin
               if (!enable || cnt == '0) begin
                  fsm     <= CLOSE;
                  pump_on <= 1'b0;
                  cnt     <= SETTLE_M1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CLOSE: begin
               // Closing always runs to completion, even if the window shuts.
               if (cnt == '0) begin
                  fsm   <= IDLE;
                  valve <= '0;
                  done  <= onehot(active_zone);
                  ptr   <= wrap_inc(active_zone);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Scoreboard bench: stimulus queues expected service records, a negedge monitor
// measures each service and compares when done pulses.
module tb_irrigation_zone_scheduler;
   localparam int NZONES = 4;
   localparam int ZW     = 2;
   localparam int TIME_W = 7;
   localparam int SETTLE = 3;

   logic                     clk;
   logic                     reset;
   logic                     enable;
   logic [NZONES-1:0]        req;
   logic [NZONES-1:0]        urgent;
   logic [NZONES*TIME_W-1:0] water_time;
   logic [NZONES-1:0]        valve;
   logic                     pump_on;
   logic [ZW-1:0]            active_zone;
   logic [NZONES-1:0]        done;
   logic [1:0]               state;

   irrigation_zone_scheduler #(
      .NZONES(NZONES), .ZW(ZW), .TIME_W(TIME_W), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .req(req), .urgent(urgent),
      .water_time(water_time), .valve(valve), .pump_on(pump_on),
      .active_zone(active_zone), .done(done), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int zone;
      int vlen;
      int plen;
      int pdly;
      int gap;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act == expv) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, expv);
   endtask

   task automatic push_exp(input int zone, input int vlen, input int plen,
                           input int pdly, input int gap);
      exp_t e;
      e.zone = zone; e.vlen = vlen; e.plen = plen; e.pdly = pdly; e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_time(input int z, input int t);
      water_time[z*TIME_W +: TIME_W] = TIME_W'(t);
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; req = '0; urgent = '0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && state == 2'b00) && n < max_cyc) begin
         tick(1);
         n++;
      end
      if (n >= max_cyc) begin
         checks++;
         $display("FAIL %s: timeout after %0d cycles, %0d services outstanding",
                  name, n, exp_q.size());
      end
      tick(2);
   endtask

   // Monitor: measure valve length, pump length, pump delay and grant gap per service.
   int cyc = 0;
   int last_done = -1000;
   int vcnt = 0, pcnt = 0, pdly = -1, meas_gap = -1;
   bit viol = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      int   z;
      cyc++;
      if (reset) begin
         vcnt = 0; pcnt = 0; pdly = -1; meas_gap = -1; viol = 1'b0;
      end else begin
         if ($countones(valve) > 1 || (pump_on && valve == '0)) viol = 1'b1;
         if (valve != '0) begin
            if (vcnt == 0) meas_gap = cyc - last_done;
            if (pump_on && pdly < 0) pdly = vcnt;
            vcnt++;
            if (pump_on) pcnt++;
         end
         if (done != '0) begin
            z = -1;
            for (int i = 0; i < NZONES; i++) if (done[i]) z = i;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_done: done=%b with no service expected", done);
            end else begin
               e = exp_q.pop_front();
               chk("done_onehot", $countones(done), 1);
               chk("done_zone", z, e.zone);
               chk("active_zone", int'(active_zone), e.zone);
               chk("valve_cycles", vcnt, e.vlen);
               chk("pump_cycles", pcnt, e.plen);
               chk("pump_delay", pdly, e.pdly);
               if (e.gap >= 0) chk("grant_gap", meas_gap, e.gap);
               chk("valve_pump_invariant", int'(viol), 0);
            end
            last_done = cyc;
            vcnt = 0; pcnt = 0; pdly = -1; meas_gap = -1; viol = 1'b0;
         end
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b0; req = '0; urgent = '0; water_time = '0;
      do_reset();
      chk("rst_valve", int'(valve), 0);
      chk("rst_pump", int'(pump_on), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_active", int'(active_zone), 0);
      chk("rst_state", int'(state), 0);

      // Single zone: zone1 T=5 -> valve 11, pump 5 starting 3 after valve rise.
      set_time(1, 5);
      push_exp(1, 11, 5, 3, -1);
      enable = 1'b1; req = 4'b0010;
      tick(1);
      req = '0;
      wait_idle("single_zone", 100);

      // Pointer now 2: zones 0 and 2 requesting, zone2 must win.
      for (int i = 0; i < NZONES; i++) set_time(i, 2);
      push_exp(2, 8, 2, 3, -1);
      req = 4'b0101;
      tick(1);
      req = '0;
      wait_idle("ptr_after_single", 100);

      // Round-robin with all requests held: 0,1,2,3,0, back-to-back grants.
      do_reset();
      enable = 1'b1;
      push_exp(0, 8, 2, 3, -1);
      push_exp(1, 8, 2, 3, 1);
      push_exp(2, 8, 2, 3, 1);
      push_exp(3, 8, 2, 3, 1);
      push_exp(0, 8, 2, 3, 1);
      req = 4'b1111;
      tick(1);
      tick(36);
      req = '0;
      wait_idle("round_robin", 200);

      // Urgent first from ptr=0, then 0, then 1; late urgent does not preempt.
      do_reset();
      enable = 1'b1;
      push_exp(2, 8, 2, 3, -1);
      push_exp(0, 8, 2, 3, 1);
      push_exp(1, 8, 2, 3, 1);
      req = 4'b0111; urgent = 4'b0100;
      tick(1);
      req = 4'b0011; urgent = 4'b0000;
      tick(9);
      req = 4'b0010; urgent = 4'b0010;
      tick(9);
      req = '0; urgent = '0;
      wait_idle("urgent", 200);

      // Abort: enable drops after 2 WATER cycles of a T=50 run.
      set_time(0, 50);
      push_exp(0, 8, 2, 3, -1);
      req = 4'b0001;
      tick(1);
      tick(4);
      enable = 1'b0;
      tick(1);
      chk("abort_pump_off", int'(pump_on), 0);
      chk("abort_state_close", int'(state), 3);
      tick(20);
      chk("no_grant_while_disabled", int'(valve), 0);
      req = '0; enable = 1'b1;
      wait_idle("abort", 100);

      // Zero time skip then zone1 T=4; mid-service time change is ignored.
      do_reset();
      enable = 1'b1;
      set_time(0, 0); set_time(1, 4);
      push_exp(0, 0, 0, -1, -1);
      push_exp(1, 10, 4, 3, 1);
      req = 4'b0011;
      tick(1);
      req = 4'b0010;
      tick(1);
      req = '0;
      tick(2);
      set_time(1, 100);
      wait_idle("zero_time", 200);

      // Reset during WATER: no done, everything cleared, pointer back to 0.
      set_time(3, 20);
      req = 4'b1000;
      tick(1);
      tick(5);
      chk("pre_reset_pump_on", int'(pump_on), 1);
      reset = 1'b1; req = '0;
      tick(1);
      reset = 1'b0;
      chk("midrst_valve", int'(valve), 0);
      chk("midrst_pump", int'(pump_on), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_state", int'(state), 0);
      chk("midrst_active", int'(active_zone), 0);
      for (int i = 0; i < NZONES; i++) set_time(i, 2);
      push_exp(0, 8, 2, 3, -1);
      enable = 1'b1; req = 4'b1111;
      tick(1);
      req = '0;
      wait_idle("after_reset_ptr", 100);

      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
